spi_slave_bmm150_model: RTL and testbench

// - Synthesizable SPI responder emulating the BMM150 register interface: 128 x 8 register file, chip ID, fabric-loaded data regs.
// - Sits on the far end of the SPI master's sclk/mosi/miso/cs_n so the master and its sequencing can be looped back on-chip without a sensor.
// - SPI mode 3: master drives MOSI on sclk fall, samples MISO on sclk rise; MSB first.
// - Frame: bit0 = rw (1=read), 7 address bits, 8 data bits.

---
 rtl/spi_slave_bmm150_model.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_bmm150_model.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_bmm150_model.sv
// SPI mode-3 responder that mimics the BMM150 register map: 128x8 regs, read-only chip ID, fabric load port.
// Define AUTO_INC_EN for multi-byte bursts with address auto-increment; otherwise frames are single-byte.
module spi_slave_bmm150_model #(
  parameter logic [7:0] CHIP_ID      = 8'h32,
  parameter logic [6:0] CHIP_ID_ADDR = 7'h40,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic       ld_we,
  input  logic [6:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev;
  logic [4:0]             bit_cnt;
  logic                   past16;
  logic                   rw;
  logic [6:0]             addr;
  logic [6:0]             rx_sr;
  logic [7:0]             tx_sr;
  logic [7:0]             regs [128];

  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, sclk_fall;
  logic [6:0] cmd_addr;
  logic [7:0] rx_byte;
  logic [7:0] cmd_rd;
  logic       spi_commit;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cmd_addr  = {rx_sr[5:0], mosi_s};
  assign rx_byte   = {rx_sr, mosi_s};
  assign cmd_rd    = (cmd_addr == CHIP_ID_ADDR) ? CHIP_ID : regs[cmd_addr];

  assign spi_commit = (state == DATA) && !cs_s && sclk_rise && (bit_cnt == 5'd15) &&
                      !rw && (addr != CHIP_ID_ADDR);

`ifdef AUTO_INC_EN
  logic [6:0] addr_inc;
  logic [7:0] inc_rd;
  assign addr_inc = addr + 7'd1;
  assign inc_rd   = (addr_inc == CHIP_ID_ADDR) ? CHIP_ID : regs[addr_inc];
`endif

  // An SPI commit beats a fabric load to the same address in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) regs[i] <= 8'h00;
    end else begin
      if (ld_we && (ld_addr != CHIP_ID_ADDR) && !(spi_commit && (ld_addr == addr)))
        regs[ld_addr] <= ld_data;
      if (spi_commit)
        regs[addr] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      past16    <= 1'b0;
      rw        <= 1'b0;
      addr      <= 7'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 8'h00;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 7'd0;
      wr_data   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_s;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Deselect aborts from any state; only whole-byte boundaries count as clean ends
      if (state != IDLE && cs_s) begin
        state     <= IDLE;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        bit_cnt   <= 5'd0;
        past16    <= 1'b0;
        frame_err <= (bit_cnt != 5'd0) && (bit_cnt != 5'd16) && !(past16 && bit_cnt == 5'd8);
      end else begin
        case (state)
          IDLE: begin
            if (!cs_s) begin
              state   <= CMD;
              bit_cnt <= 5'd0;
              past16  <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[5:0], mosi_s};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                rw      <= rx_sr[6];
                addr    <= cmd_addr;
                tx_sr   <= cmd_rd;
                miso_oe <= rx_sr[6];
                state   <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_fall && rw) begin
              miso  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[5:0], mosi_s};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                if (!rw && (addr != CHIP_ID_ADDR)) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= addr;
                  wr_data  <= rx_byte;
                end
`ifdef AUTO_INC_EN
                addr    <= addr_inc;
                tx_sr   <= inc_rd;
                bit_cnt <= 5'd8;
                past16  <= 1'b1;
`else
                state   <= HOLD;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
`endif
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bmm150_model.sv
// Randomized bench for spi_slave_bmm150_model against an array-based register map model.
// Compile with AUTO_INC_EN defined to exercise burst transfers instead of the single-byte hold case.
module tb_spi_slave_bmm150_model;

  localparam logic [7:0] CID   = 8'h32;
  localparam logic [6:0] CADDR = 7'h40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b1;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       ld_we = 1'b0;
  logic [6:0] ld_addr = 7'd0;
  logic [7:0] ld_data = 8'h00;
  logic       miso, miso_oe, wr_valid, frame_err;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  int n_vec = 0;
  int n_bad = 0;
  int wr_seen = 0;
  int err_seen = 0;
  int rise_n = 0;
  logic [6:0] last_wa = 7'd0;
  logic [7:0] last_wd = 8'h00;
  logic [7:0] model [128];

  always #10 clk = ~clk;

  spi_slave_bmm150_model dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_seen++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (frame_err) err_seen++;
  end

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    return (a == CADDR) ? CID : model[a];
  endfunction

  // Mode-3 master: 100 ns half periods, every edge at a fixed phase to clk
  task automatic spi_xfer(input int nbits, input logic [31:0] out_bits, input bit keep_cs,
                          input int ld_bit, input int ld_dly, input logic [6:0] la,
                          input logic [7:0] lv, output logic [31:0] in_bits, output int oe_cnt);
    in_bits = 32'h0;
    oe_cnt  = 0;
    rise_n  = 0;
    @(negedge clk);
    #3;
    cs_n = 1'b0;
    #100;
    fork
      begin
        for (int i = 0; i < nbits; i++) begin
          sclk = 1'b0;
          mosi = out_bits[nbits-1-i];
          #100;
          sclk = 1'b1;
          rise_n = i + 1;
          in_bits = {in_bits[30:0], miso};
          if (miso_oe) oe_cnt++;
          #100;
        end
      end
      begin
        if (ld_bit > 0 && ld_bit <= nbits) begin
          wait (rise_n == ld_bit);
          repeat (ld_dly) @(negedge clk);
          ld_we = 1'b1; ld_addr = la; ld_data = lv;
          @(negedge clk);
          ld_we = 1'b0;
        end
      end
    join
    if (!keep_cs) begin
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [31:0] rx; int oe;
    spi_xfer(16, {16'h0, 1'b0, a, d}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] d, output int oe);
    logic [31:0] rx;
    spi_xfer(16, {16'h0, 1'b1, a, 8'h00}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    d = rx[7:0];
  endtask

  task automatic fab_load(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
    if (a != CADDR) model[a] = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({miso, miso_oe} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_miso got %b want 00", {miso, miso_oe}); end
    n_vec++; if ({wr_valid, frame_err} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_pulses got %b want 00", {wr_valid, frame_err}); end
    n_vec++; if ({wr_addr, wr_data} !== 15'h0) begin n_bad++; $display("[TB] FAIL reset_wr got %h want 0", {wr_addr, wr_data}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_chip_id();
    logic [31:0] rx; int oe; int w0;
    w0 = wr_seen;
    spi_xfer(16, {16'h0, 1'b1, CADDR, 8'h00}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    n_vec++; if (rx[7:0] !== CID) begin n_bad++; $display("[TB] FAIL chip_id got %h want %h", rx[7:0], CID); end
    n_vec++; if (oe !== 8) begin n_bad++; $display("[TB] FAIL chip_id_oe got %0d want 8", oe); end
    n_vec++; if (rx[15:8] !== 8'h00) begin n_bad++; $display("[TB] FAIL chip_id_idle_miso got %h want 00", rx[15:8]); end
    n_vec++; if (wr_seen - w0 !== 0) begin n_bad++; $display("[TB] FAIL chip_id_wr got %0d want 0", wr_seen - w0); end
  endtask

  task automatic test_write_read();
    logic [7:0] d; int oe; int w0;
    w0 = wr_seen;
    spi_write(7'h4B, 8'h01);
    model[7'h4B] = 8'h01;
    n_vec++; if (wr_seen - w0 !== 1) begin n_bad++; $display("[TB] FAIL wr_pulse got %0d want 1", wr_seen - w0); end
    n_vec++; if (last_wa !== 7'h4B) begin n_bad++; $display("[TB] FAIL wr_addr got %h want 4b", last_wa); end
    n_vec++; if (last_wd !== 8'h01) begin n_bad++; $display("[TB] FAIL wr_data got %h want 01", last_wd); end
    spi_read(7'h4B, d, oe);
    n_vec++; if (d !== model_rd(7'h4B)) begin n_bad++; $display("[TB] FAIL rd_4b got %h want %h", d, model_rd(7'h4B)); end
  endtask

  task automatic test_chip_write();
    logic [7:0] d; int oe; int w0;
    w0 = wr_seen;
    spi_write(CADDR, 8'hFF);
    n_vec++; if (wr_seen - w0 !== 0) begin n_bad++; $display("[TB] FAIL chip_wr_pulse got %0d want 0", wr_seen - w0); end
    spi_read(CADDR, d, oe);
    n_vec++; if (d !== CID) begin n_bad++; $display("[TB] FAIL chip_wr_rd got %h want %h", d, CID); end
  endtask

  task automatic test_abort();
    logic [31:0] rx; logic [7:0] d; int oe; int w0; int e0;
    spi_write(7'h50, 8'h3C);
    model[7'h50] = 8'h3C;
    w0 = wr_seen; e0 = err_seen;
    spi_xfer(12, {20'h0, 1'b0, 7'h50, 4'hF}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    n_vec++; if (err_seen - e0 !== 1) begin n_bad++; $display("[TB] FAIL abort_err got %0d want 1", err_seen - e0); end
    n_vec++; if (wr_seen - w0 !== 0) begin n_bad++; $display("[TB] FAIL abort_wr got %0d want 0", wr_seen - w0); end
    spi_read(7'h50, d, oe);
    n_vec++; if (d !== model_rd(7'h50)) begin n_bad++; $display("[TB] FAIL abort_reg got %h want %h", d, model_rd(7'h50)); end
    e0 = err_seen;
    spi_xfer(0, 32'h0, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    n_vec++; if (err_seen - e0 !== 0) begin n_bad++; $display("[TB] FAIL empty_frame_err got %0d want 0", err_seen - e0); end
  endtask

  task automatic test_collision();
    logic [31:0] rx; logic [7:0] d; int oe; int n; int w0;
    n = 0;
    rise_n = 0;
    fork
      spi_xfer(16, {16'h0, 1'b0, 7'h42, 8'h00}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
      begin
        wait (rise_n == 16);
        while (!wr_valid && n < 40) begin @(negedge clk); n++; end
      end
    join
    model[7'h42] = 8'h00;
    n_vec++; if (n >= 40) begin n_bad++; $display("[TB] FAIL commit_timeout got %0d want <40", n); end
    w0 = wr_seen;
    spi_xfer(16, {16'h0, 1'b0, 7'h42, 8'h5A}, 1'b0, 16, n - 1, 7'h42, 8'hA5, rx, oe);
    model[7'h42] = 8'h5A;
    spi_xfer(16, {16'h0, 1'b0, 7'h44, 8'h77}, 1'b0, 16, n - 1, 7'h43, 8'h11, rx, oe);
    model[7'h43] = 8'h11;
    model[7'h44] = 8'h77;
    n_vec++; if (wr_seen - w0 !== 2) begin n_bad++; $display("[TB] FAIL coll_wr got %0d want 2", wr_seen - w0); end
    for (int a = 'h42; a <= 'h44; a++) begin
      spi_read(7'(a), d, oe);
      n_vec++; if (d !== model_rd(7'(a))) begin n_bad++; $display("[TB] FAIL coll_rd_%h got %h want %h", a, d, model_rd(7'(a))); end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] rx; logic [7:0] d; int oe;
    fab_load(7'h45, 8'h66);
    spi_xfer(16, {16'h0, 1'b1, 7'h45, 8'h00}, 1'b0, 10, 2, 7'h45, 8'h99, rx, oe);
    n_vec++; if (rx[7:0] !== 8'h66) begin n_bad++; $display("[TB] FAIL snapshot got %h want 66", rx[7:0]); end
    model[7'h45] = 8'h99;
    spi_read(7'h45, d, oe);
    n_vec++; if (d !== model_rd(7'h45)) begin n_bad++; $display("[TB] FAIL snapshot_after got %h want %h", d, model_rd(7'h45)); end
  endtask

  task automatic test_random();
    logic [6:0] a; logic [7:0] d, r; int oe; int w0; int want;
    for (int k = 0; k < 24; k++) begin
      a = 7'h40 + 7'($urandom_range(0, 7));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: fab_load(a, d);
        1: begin
          w0 = wr_seen;
          spi_write(a, d);
          want = (a != CADDR) ? 1 : 0;
          if (a != CADDR) model[a] = d;
          n_vec++; if (wr_seen - w0 !== want) begin n_bad++; $display("[TB] FAIL rand_wr_%0d got %0d want %0d", k, wr_seen - w0, want); end
        end
        default: begin
          spi_read(a, r, oe);
          n_vec++; if (r !== model_rd(a)) begin n_bad++; $display("[TB] FAIL rand_rd_%0d addr %h got %h want %h", k, a, r, model_rd(a)); end
        end
      endcase
    end
  endtask

`ifdef AUTO_INC_EN
  task automatic test_auto_inc();
    logic [31:0] rx; logic [7:0] d; int oe; int w0; int e0;
    fab_load(7'h42, 8'h10);
    fab_load(7'h43, 8'h20);
    fab_load(7'h44, 8'h30);
    e0 = err_seen;
    spi_xfer(32, {1'b1, 7'h42, 24'h0}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    n_vec++; if (rx[23:0] !== {model[7'h42], model[7'h43], model[7'h44]}) begin n_bad++; $display("[TB] FAIL burst_rd got %h want 102030", rx[23:0]); end
    n_vec++; if (oe !== 24) begin n_bad++; $display("[TB] FAIL burst_oe got %0d want 24", oe); end
    n_vec++; if (err_seen - e0 !== 0) begin n_bad++; $display("[TB] FAIL burst_err got %0d want 0", err_seen - e0); end
    w0 = wr_seen;
    spi_xfer(24, {8'h0, 1'b0, 7'h46, 8'hAB, 8'hCD}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    model[7'h46] = 8'hAB;
    model[7'h47] = 8'hCD;
    n_vec++; if (wr_seen - w0 !== 2) begin n_bad++; $display("[TB] FAIL burst_wr got %0d want 2", wr_seen - w0); end
    n_vec++; if (last_wa !== 7'h47) begin n_bad++; $display("[TB] FAIL burst_wa got %h want 47", last_wa); end
    spi_read(7'h47, d, oe);
    n_vec++; if (d !== model_rd(7'h47)) begin n_bad++; $display("[TB] FAIL burst_wr_rd got %h want %h", d, model_rd(7'h47)); end
  endtask
`else
  task automatic test_hold();
    logic [31:0] rx; logic [7:0] d; int oe; int w0; int e0;
    w0 = wr_seen; e0 = err_seen;
    spi_xfer(24, {8'h0, 1'b0, 7'h48, 8'hAB, 8'hCD}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    model[7'h48] = 8'hAB;
    n_vec++; if (wr_seen - w0 !== 1) begin n_bad++; $display("[TB] FAIL hold_wr got %0d want 1", wr_seen - w0); end
    n_vec++; if (last_wd !== 8'hAB) begin n_bad++; $display("[TB] FAIL hold_wd got %h want ab", last_wd); end
    n_vec++; if (err_seen - e0 !== 0) begin n_bad++; $display("[TB] FAIL hold_err got %0d want 0", err_seen - e0); end
    spi_read(7'h49, d, oe);
    n_vec++; if (d !== model_rd(7'h49)) begin n_bad++; $display("[TB] FAIL hold_next got %h want %h", d, model_rd(7'h49)); end
    spi_xfer(24, {8'h0, 1'b1, 7'h48, 16'h0}, 1'b0, 0, 0, 7'd0, 8'h00, rx, oe);
    n_vec++; if (rx[15:0] !== {model[7'h48], 8'h00}) begin n_bad++; $display("[TB] FAIL hold_rd got %h want ab00", rx[15:0]); end
    n_vec++; if (oe !== 8) begin n_bad++; $display("[TB] FAIL hold_oe got %0d want 8", oe); end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [31:0] rx; logic [7:0] d; int oe;
    spi_xfer(10, {22'h0, 1'b1, CADDR, 2'b00}, 1'b1, 0, 0, 7'd0, 8'h00, rx, oe);
    n_vec++; if (miso_oe !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_oe_before got %b want 1", miso_oe); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (miso_oe !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_oe_reset got %b want 0", miso_oe); end
    cs_n = 1'b1;
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    spi_read(7'h4B, d, oe);
    n_vec++; if (d !== model_rd(7'h4B)) begin n_bad++; $display("[TB] FAIL mid_regs_cleared got %h want %h", d, model_rd(7'h4B)); end
  endtask

  initial begin
    test_reset();
    test_chip_id();
    test_write_read();
    test_chip_write();
    test_abort();
    test_collision();
    test_snapshot();
    test_random();
`ifdef AUTO_INC_EN
    test_auto_inc();
`else
    test_hold();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
